// File: rtl/program_loader_if.sv
// Byte-stream and program-memory signal bundle for program_loader.
// slave = the loader itself; master = the environment (stream source plus memory).
interface program_loader_if #(
   parameter int ADDR_W = 16
);
   // A byte moves on a rising clk edge where in_valid and in_ready are both high.
   // The source holds in_data stable while in_valid is high and in_ready is low.
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;
   logic [ADDR_W-1:0] mem_address;
   logic [31:0]       mem_writedata;
   logic [3:0]        mem_byteenable;
   logic              mem_chipselect;
   logic              mem_write;
   logic              mem_clken;
   logic [31:0]       mem_readdata;

   modport slave (
      input  in_valid, in_data, mem_readdata,
      output in_ready, mem_address, mem_writedata, mem_byteenable,
             mem_chipselect, mem_write, mem_clken
   );

   modport master (
      output in_valid, in_data, mem_readdata,
      input  in_ready, mem_address, mem_writedata, mem_byteenable,
             mem_chipselect, mem_write, mem_clken
   );
endinterface

// File: rtl/program_loader.sv
// Loads a checksummed firmware image from a byte stream into program memory while holding the CPU in reset.
// Define PROGRAM_LOADER_READBACK_EN to read back and verify every written word.
module program_loader #(
   parameter int MEM_WORDS = 40960,
   parameter int ADDR_W    = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   program_loader_if.slave      bus,
   output logic                 cpu_reset_req,
   output logic                 busy,
   output logic                 done,
   output logic                 error,
   output logic [1:0]           err_code,
   output logic [3:0]           dbg_state
);

   typedef enum logic [3:0] {
      ST_IDLE  = 4'd0,
      ST_HDR   = 4'd1,
      ST_DATA  = 4'd2,
      ST_WRITE = 4'd3,
      ST_RD    = 4'd4,
      ST_CMP   = 4'd5,
      ST_CSUM  = 4'd6,
      ST_DONE  = 4'd7,
      ST_ERR   = 4'd8
   } state_t;

   state_t      state, state_next;
   logic [1:0]  hdr_cnt;
   logic [1:0]  lane;
   logic [15:0] addr;
   logic [15:0] remaining;
   logic [31:0] word_buf;
   logic [7:0]  sum;

   logic        ready_c;
   logic        accept;
   logic        advance;
   logic        set_ok;
   logic        set_err;
   logic [1:0]  err_val;
   logic [15:0] count_full;
   logic [16:0] end_sum;

   assign accept     = bus.in_valid & ready_c;
   // Header bytes 2 and 3 are the word count; byte 3 is still on the bus when the range is checked.
   assign count_full = {bus.in_data, remaining[7:0]};
   assign end_sum    = {1'b0, addr} + {1'b0, count_full};

   always_comb begin
      state_next = state;
      ready_c    = 1'b0;
      advance    = 1'b0;
      set_ok     = 1'b0;
      set_err    = 1'b0;
      err_val    = 2'd0;
      case (state)
         ST_IDLE: begin
            if (start) state_next = ST_HDR;
         end
         ST_HDR: begin
            ready_c = 1'b1;
            if (bus.in_valid && hdr_cnt == 2'd3) begin
               if (end_sum > 17'(MEM_WORDS)) begin
                  state_next = ST_ERR;
                  set_err    = 1'b1;
                  err_val    = 2'd1;
               end else if (count_full == 16'd0) begin
                  state_next = ST_CSUM;
               end else begin
                  state_next = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            ready_c = 1'b1;
            if (bus.in_valid && lane == 2'd3) state_next = ST_WRITE;
         end
         ST_WRITE: begin
`ifdef PROGRAM_LOADER_READBACK_EN
            state_next = ST_RD;
`else
            advance    = 1'b1;
            state_next = (remaining == 16'd1) ? ST_CSUM : ST_DATA;
`endif
         end
`ifdef PROGRAM_LOADER_READBACK_EN
         ST_RD: begin
            state_next = ST_CMP;
         end
         ST_CMP: begin
            if (bus.mem_readdata != word_buf) begin
               state_next = ST_ERR;
               set_err    = 1'b1;
               err_val    = 2'd3;
            end else begin
               advance    = 1'b1;
               state_next = (remaining == 16'd1) ? ST_CSUM : ST_DATA;
            end
         end
`endif
         ST_CSUM: begin
            ready_c = 1'b1;
            if (bus.in_valid) begin
               if (8'(sum + bus.in_data) == 8'h00) begin
                  state_next = ST_DONE;
                  set_ok     = 1'b1;
               end else begin
                  state_next = ST_ERR;
                  set_err    = 1'b1;
                  err_val    = 2'd2;
               end
            end
         end
         ST_DONE: state_next = ST_IDLE;
         ST_ERR:  state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= ST_IDLE;
         hdr_cnt       <= 2'd0;
         lane          <= 2'd0;
         addr          <= 16'd0;
         remaining     <= 16'd0;
         word_buf      <= 32'd0;
         sum           <= 8'd0;
         busy          <= 1'b0;
         done          <= 1'b0;
         error         <= 1'b0;
         err_code      <= 2'd0;
         cpu_reset_req <= 1'b0;
      end else begin
         state <= state_next;
         if (state == ST_IDLE && start) begin
            done          <= 1'b0;
            error         <= 1'b0;
            err_code      <= 2'd0;
            busy          <= 1'b1;
            cpu_reset_req <= 1'b1;
            hdr_cnt       <= 2'd0;
            lane          <= 2'd0;
            sum           <= 8'd0;
         end
         if (accept) sum <= sum + bus.in_data;
         if (state == ST_HDR && accept) begin
            hdr_cnt <= hdr_cnt + 2'd1;
            case (hdr_cnt)
               2'd0:    addr[7:0]       <= bus.in_data;
               2'd1:    addr[15:8]      <= bus.in_data;
               2'd2:    remaining[7:0]  <= bus.in_data;
               default: remaining[15:8] <= bus.in_data;
            endcase
         end
         // Shifting in from the top leaves byte 0 in bits [7:0] after four bytes.
         if (state == ST_DATA && accept) begin
            word_buf <= {bus.in_data, word_buf[31:8]};
            lane     <= lane + 2'd1;
         end
         if (advance) begin
            addr      <= addr + 16'd1;
            remaining <= remaining - 16'd1;
         end
         if (set_ok) begin
            busy          <= 1'b0;
            done          <= 1'b1;
            cpu_reset_req <= 1'b0;
         end
         // cpu_reset_req is left high on failure so corrupt firmware never runs.
         if (set_err) begin
            busy     <= 1'b0;
            error    <= 1'b1;
            err_code <= err_val;
         end
      end
   end

   assign bus.in_ready       = ready_c;
   assign bus.mem_chipselect = (state == ST_WRITE) || (state == ST_RD);
   assign bus.mem_write      = (state == ST_WRITE);
   assign bus.mem_byteenable = (state == ST_WRITE) ? 4'hF : 4'h0;
   assign bus.mem_clken      = 1'b1;
   assign bus.mem_address    = addr[ADDR_W-1:0];
   assign bus.mem_writedata  = word_buf;
   assign dbg_state          = state;

`ifndef PROGRAM_LOADER_READBACK_EN
   logic unused_readdata;
   assign unused_readdata = ^bus.mem_readdata;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: image-level model of expected writes and final status,
// a per-cycle write monitor against that model, and a behavioural program memory.
module tb_program_loader;
   localparam int MEM_WORDS = 40960;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       start = 1'b0;
   logic       cpu_reset_req, busy, done, error;
   logic [1:0] err_code;
   logic [3:0] dbg_state;

   program_loader_if #(.ADDR_W(16)) bus();

   program_loader #(.MEM_WORDS(MEM_WORDS), .ADDR_W(16)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .start         (start),
      .bus           (bus),
      .cpu_reset_req (cpu_reset_req),
      .busy          (busy),
      .done          (done),
      .error         (error),
      .err_code      (err_code),
      .dbg_state     (dbg_state)
   );

   always #5 clk = ~clk;

   // Program memory: synchronous write, read data one cycle after the address.
   logic [31:0] mem [0:65535];
   logic [31:0] rd_q = 32'd0;
   logic        corrupt_rd = 1'b0;
   always @(posedge clk) begin
      if (bus.mem_chipselect && bus.mem_write) mem[bus.mem_address] <= bus.mem_writedata;
      rd_q <= mem[bus.mem_address] ^ (corrupt_rd ? 32'h0000_0001 : 32'h0);
   end
   assign bus.mem_readdata = rd_q;

   // Scoreboard state.
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [47:0] exp_q[$];
   logic [47:0] exp_e;
   logic        exp_err;
   logic [1:0]  exp_code;
   int          exp_nsend;
   bit          rb_corrupt = 1'b0;
   logic [31:0] img_words[$];
   logic [7:0]  img_bytes[$];

   task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Write monitor: every mem_write must be the next expected (address, data) pair.
   always @(negedge clk) begin
      if (reset_n) begin
         check("clken_and_no_ready_on_write", {46'd0, bus.mem_clken, bus.mem_write & bus.in_ready},
               {46'd0, 1'b1, 1'b0});
         if (bus.mem_write) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_write: got addr %h data %h, expected no write",
                        bus.mem_address, bus.mem_writedata);
            end else begin
               exp_e = exp_q.pop_front();
               check("write_addr_data", {bus.mem_address, bus.mem_writedata}, exp_e);
               check("write_byteenable", {44'd0, bus.mem_byteenable}, 48'hF);
            end
         end
      end
   end

   task automatic build_image(input logic [15:0] s, input logic [15:0] c, input logic [7:0] adj);
      logic [7:0] acc;
      img_bytes.delete();
      img_bytes.push_back(s[7:0]);
      img_bytes.push_back(s[15:8]);
      img_bytes.push_back(c[7:0]);
      img_bytes.push_back(c[15:8]);
      foreach (img_words[i]) begin
         for (int b = 0; b < 4; b++) img_bytes.push_back(img_words[i][8*b +: 8]);
      end
      acc = 8'd0;
      foreach (img_bytes[i]) acc = acc + img_bytes[i];
      img_bytes.push_back(8'(8'h00 - acc + adj));
   endtask

   // Image-level outcome: which words land where, and how the session ends.
   task automatic model(input logic [15:0] s, input logic [15:0] c, input bit csum_bad);
      if (({1'b0, s} + {1'b0, c}) > 17'(MEM_WORDS)) begin
         exp_err   = 1'b1;
         exp_code  = 2'd1;
         exp_nsend = 4;
      end else if (rb_corrupt) begin
         exp_q.push_back({s, img_words[0]});
         exp_err   = 1'b1;
         exp_code  = 2'd3;
         exp_nsend = 8;
      end else begin
         for (int i = 0; i < int'(c); i++) exp_q.push_back({16'(s + 16'(i)), img_words[i]});
         exp_err   = csum_bad;
         exp_code  = csum_bad ? 2'd2 : 2'd0;
         exp_nsend = img_bytes.size();
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gaps);
      int budget;
      if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      budget = 0;
      while (!bus.in_ready && budget < 50) begin
         @(negedge clk);
         budget++;
      end
      if (budget >= 50) begin
         n_cmp++;
         n_bad++;
         $display("FAIL byte_accept_timeout: got in_ready=0 (state %0d), expected 1", dbg_state);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic run_session(input logic [15:0] s, input logic [15:0] c,
                              input logic [7:0] adj, input bit gaps);
      int k;
      build_image(s, c, adj);
      model(s, c, adj != 8'd0);
      pulse_start();
      check("busy_after_start", {46'd0, busy, cpu_reset_req}, {46'd0, 2'b11});
      if (gaps) begin
         fork
            begin
               repeat (6) @(negedge clk);
               check("busy_at_second_start", {47'd0, busy}, 48'd1);
               start = 1'b1;
               @(negedge clk);
               start = 1'b0;
            end
         join_none
      end
      for (int i = 0; i < exp_nsend; i++) send_byte(img_bytes[i], gaps);
      k = 0;
      while (!(done || error) && k < 30) begin
         @(negedge clk);
         k++;
      end
      if (k >= 30) begin
         n_cmp++;
         n_bad++;
         $display("FAIL finish_timeout: got done=0 error=0, expected one of them");
      end
      check("final_status", {42'd0, busy, done, error, cpu_reset_req, err_code},
            {42'd0, 1'b0, ~exp_err, exp_err, exp_err, exp_code});
      check("all_writes_seen", 48'(exp_q.size()), 48'd0);
      exp_q.delete();
      repeat (2) @(negedge clk);
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'd0;
      repeat (3) @(negedge clk);
      check("reset_flags", {42'd0, busy, done, error, cpu_reset_req, err_code}, 48'd0);
      check("reset_bus", {40'd0, bus.in_ready, bus.mem_write, bus.mem_chipselect, bus.mem_clken,
                          bus.mem_byteenable}, {40'd0, 4'b0001, 4'h0});
      check("reset_addr_data", {bus.mem_address, bus.mem_writedata}, 48'd0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // Two-word image at address 0.
      img_words = '{32'h11223344, 32'hA5A5A5A5};
      run_session(16'h0000, 16'd2, 8'd0, 1'b0);
      check("csum_byte_literal", {40'd0, img_bytes[img_bytes.size()-1]}, 48'hC0);
      check("mem0_literal", {16'd0, mem[0]}, 48'h0000_1122_3344);
      check("mem1_literal", {16'd0, mem[1]}, 48'h0000_A5A5_A5A5);

      // 0x9FFF + 2 = 0xA001 runs past the implemented words.
      run_session(16'h9FFF, 16'd2, 8'd0, 1'b0);
      check("range_err_literal", {46'd0, err_code}, 48'd1);

      // One word, checksum off by one.
      img_words = '{32'hDEADBEEF};
      run_session(16'h0010, 16'd1, 8'd1, 1'b0);
      check("csum_err_word_written", {16'd0, mem[16]}, 48'h0000_DEAD_BEEF);

      // Empty image: header plus checksum only.
      img_words = {};
      run_session(16'h0040, 16'd0, 8'd0, 1'b0);
      check("empty_image_len", 48'(img_bytes.size()), 48'd5);
      check("empty_csum_literal", {40'd0, img_bytes[4]}, 48'hC0);

      // Same data as the first image, with random gaps and a stray start while busy.
      img_words = '{32'h11223344, 32'hA5A5A5A5};
      run_session(16'h0100, 16'd2, 8'd0, 1'b1);
      check("gap_mem0", {16'd0, mem[16'h0100]}, 48'h0000_1122_3344);
      check("gap_mem1", {16'd0, mem[16'h0101]}, 48'h0000_A5A5_A5A5);

      // Reset in the middle of the first data word.
      img_words = '{32'hCAFEF00D, 32'h01020304, 32'h0BADC0DE};
      build_image(16'h0020, 16'd3, 8'd0);
      pulse_start();
      for (int i = 0; i < 6; i++) send_byte(img_bytes[i], 1'b0);
      reset_n = 1'b0;
      #1;
      check("midreset_flags", {42'd0, busy, done, error, cpu_reset_req, err_code}, 48'd0);
      check("midreset_bus", {44'd0, bus.in_ready, bus.mem_write, bus.mem_chipselect, bus.mem_clken},
            48'd1);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      img_words = '{32'h13579BDF, 32'h2468ACE0};
      run_session(16'h0030, 16'd2, 8'd0, 1'b0);
      check("after_reset_mem0", {16'd0, mem[16'h0030]}, 48'h0000_1357_9BDF);
      check("after_reset_mem1", {16'd0, mem[16'h0031]}, 48'h0000_2468_ACE0);

`ifdef PROGRAM_LOADER_READBACK_EN
      // Readback returns a flipped bit: first word written, then verify error.
      corrupt_rd = 1'b1;
      rb_corrupt = 1'b1;
      img_words  = '{32'h55AA55AA, 32'h12345678};
      run_session(16'h0200, 16'd2, 8'd0, 1'b0);
      check("verify_err_literal", {46'd0, err_code}, 48'd3);
      corrupt_rd = 1'b0;
      rb_corrupt = 1'b0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
